// File: rtl/mxu_pkg.sv
// Shared definitions for the MXU host controller: FSM states and the
// MXU register map used on the write and read channels.
package mxu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        W_GAP,
        WAIT,
        R_ADDR,
        R_WAIT
    } state_t;

    localparam logic [31:0] ADDR_CTRL     = 32'd0;
    localparam logic [31:0] ADDR_CYCLES   = 32'd1;
    localparam logic [31:0] ADDR_A_BASE   = 32'd2;
    localparam logic [31:0] ADDR_ACC_BASE = 32'd1;
    localparam logic [7:0]  CTRL_START    = 8'h01;

endpackage

// File: rtl/mxu_host.sv
// Host-side sequencer for one MXU multiply: loads A, B and the cycle count,
// kicks the unit, waits out the compute time, then streams the results back.
module mxu_host
    import mxu_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int RD_LAT   = 2,
    parameter int WAIT_MUL = 3,
    parameter int WAIT_ADD = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SIZE*SIZE*8-1:0] a_mat,
    input  logic [SIZE*SIZE*8-1:0] b_mat,
    input  logic [7:0]             cycles,
    output logic [31:0]            awaddr,
    output logic [7:0]             wdata,
    output logic                   wready,
    output logic [31:0]            araddr,
    output logic                   arready,
    input  logic [31:0]            rdata,
    output logic                   res_valid,
    output logic [7:0]             res_idx,
    output logic [31:0]            res_data,
    output logic                   busy,
    output logic                   done
);

    localparam int NN       = SIZE * SIZE;
    localparam int NWR      = 2 * NN + 2;
    localparam int IDX_W    = $clog2(NWR + 1);
    localparam int WAIT_MAX = 255 * WAIT_MUL + WAIT_ADD;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int LAT_W    = $clog2(RD_LAT + 1);

    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_NN      = IDX_W'(NN);
    localparam logic [IDX_W-1:0] IDX_2NN     = IDX_W'(2 * NN);
    localparam logic [IDX_W-1:0] IDX_LAST_WR = IDX_W'(NWR - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_RD = IDX_W'(NN - 1);

    // Write n of the load sequence: A and B are contiguous from ADDR_A_BASE,
    // followed by the cycle register and finally the start command.
    function automatic logic [31:0] f_waddr(input logic [IDX_W-1:0] n);
        if (n < IDX_2NN)
            return ADDR_A_BASE + 32'(n);
        else if (n == IDX_2NN)
            return ADDR_CYCLES;
        return ADDR_CTRL;
    endfunction

    function automatic logic [7:0] f_wdata(input logic [IDX_W-1:0]  n,
                                           input logic [NN*8-1:0]   a,
                                           input logic [NN*8-1:0]   b,
                                           input logic [7:0]        cyc);
        if (n < IDX_NN)
            return 8'(a >> {n, 3'b000});
        else if (n < IDX_2NN)
            return 8'(b >> {n - IDX_NN, 3'b000});
        else if (n == IDX_2NN)
            return cyc;
        return CTRL_START;
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [WAIT_W-1:0]  r_wait;
    logic [LAT_W-1:0]   r_lat;
    logic [NN*8-1:0]    r_a;
    logic [NN*8-1:0]    r_b;
    logic [7:0]         r_cycles;
    logic [31:0]        r_awaddr;
    logic [7:0]         r_wdata;
    logic [31:0]        r_araddr;
    logic               r_res_valid;
    logic [7:0]         r_res_idx;
    logic [31:0]        r_res_data;
    logic               r_done;
    logic               w_wready;
    logic               w_arready;
    logic               w_start_ok;
    logic [WAIT_W-1:0]  w_wait_len;

    // A start landing on the done cycle is still part of the finished run.
    assign w_start_ok = start && !r_done;
    assign w_wait_len = WAIT_W'(r_cycles) * WAIT_W'(WAIT_MUL) + WAIT_W'(WAIT_ADD);

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_wready  = 1'b0;
        w_arready = 1'b0;
        case (r_state)
            IDLE:   if (w_start_ok) w_next = W_ADDR;
            W_ADDR: w_next = W_DATA;
            W_DATA: begin
                w_wready = 1'b1;
                w_next   = W_GAP;
            end
            W_GAP: begin
                if (r_idx != IDX_LAST_WR)
                    w_next = W_ADDR;
                else if (w_wait_len == '0)
                    w_next = R_ADDR;
                else
                    w_next = WAIT;
            end
            WAIT:   if (r_wait == '0) w_next = R_ADDR;
            R_ADDR: begin
                w_arready = 1'b1;
                w_next    = R_WAIT;
            end
            // r_idx == NN marks the cycle carrying the final result pulse.
            R_WAIT: begin
                if (r_idx == IDX_NN)
                    w_next = IDLE;
                else if (r_lat == '0 && r_idx != IDX_LAST_RD)
                    w_next = R_ADDR;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx       <= '0;
            r_wait      <= '0;
            r_lat       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cycles    <= '0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_araddr    <= '0;
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_a      <= a_mat;
                        r_b      <= b_mat;
                        r_cycles <= cycles;
                        r_idx    <= '0;
                        r_awaddr <= f_waddr('0);
                    end
                end
                W_ADDR: r_wdata <= f_wdata(r_idx, r_a, r_b, r_cycles);
                W_GAP: begin
                    if (r_idx == IDX_LAST_WR) begin
                        r_idx  <= '0;
                        r_wait <= w_wait_len - WAIT_W'(1);
                        if (w_wait_len == '0)
                            r_araddr <= ADDR_ACC_BASE;
                    end else begin
                        r_idx    <= r_idx + IDX_ONE;
                        r_awaddr <= f_waddr(r_idx + IDX_ONE);
                    end
                end
                WAIT: begin
                    if (r_wait == '0)
                        r_araddr <= ADDR_ACC_BASE;
                    else
                        r_wait <= r_wait - WAIT_W'(1);
                end
                R_ADDR: r_lat <= LAT_W'(RD_LAT - 1);
                R_WAIT: begin
                    if (r_idx == IDX_NN) begin
                        r_done <= 1'b1;
                    end else if (r_lat == '0) begin
                        r_res_valid <= 1'b1;
                        r_res_idx   <= 8'(r_idx);
                        r_res_data  <= rdata;
                        r_idx       <= r_idx + IDX_ONE;
                        if (r_idx != IDX_LAST_RD)
                            r_araddr <= ADDR_ACC_BASE + 32'(r_idx) + 32'd1;
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign awaddr    = r_awaddr;
    assign wdata     = r_wdata;
    assign wready    = w_wready;
    assign araddr    = r_araddr;
    assign arready   = w_arready;
    assign res_valid = r_res_valid;
    assign res_idx   = r_res_idx;
    assign res_data  = r_res_data;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_mxu_host.sv
// Randomized bench for mxu_host with a behavioural MXU and a matrix-level
// reference for the expected write sequence, timing and results.
module tb_mxu_host;

    localparam int SIZE     = 4;
    localparam int RD_LAT   = 2;
    localparam int WAIT_MUL = 3;
    localparam int WAIT_ADD = 5;
    localparam int NN       = SIZE * SIZE;
    localparam int NWR      = 2 * NN + 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [NN*8-1:0]    a_mat;
    logic [NN*8-1:0]    b_mat;
    logic [7:0]         cycles;
    logic [31:0]        awaddr;
    logic [7:0]         wdata;
    logic               wready;
    logic [31:0]        araddr;
    logic               arready;
    logic [31:0]        rdata;
    logic               res_valid;
    logic [7:0]         res_idx;
    logic [31:0]        res_data;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    mxu_host #(
        .SIZE    (SIZE),
        .RD_LAT  (RD_LAT),
        .WAIT_MUL(WAIT_MUL),
        .WAIT_ADD(WAIT_ADD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_mat    (a_mat),
        .b_mat    (b_mat),
        .cycles   (cycles),
        .awaddr   (awaddr),
        .wdata    (wdata),
        .wready   (wready),
        .araddr   (araddr),
        .arready  (arready),
        .rdata    (rdata),
        .res_valid(res_valid),
        .res_idx  (res_idx),
        .res_data (res_data),
        .busy     (busy),
        .done     (done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural MXU: register file written by the host, reads answered
    // exactly RD_LAT cycles after the address pulse, garbage otherwise.
    logic [7:0]  mem [0:63];
    bit          pv [RD_LAT];
    logic [31:0] pa [RD_LAT];
    bit          prod_mode;

    always @(posedge clk) begin
        if (wready === 1'b1) mem[awaddr[5:0]] <= wdata;
        pv[0] <= (arready === 1'b1);
        pa[0] <= araddr;
        for (int i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end

    function automatic logic [31:0] mxu_read(input logic [31:0] addr);
        int k, r, c, acc;
        if (!prod_mode) return 32'd1000 + addr;
        k = int'(addr) - 1;
        r = k / SIZE;
        c = k % SIZE;
        acc = 0;
        for (int m = 0; m < SIZE; m++)
            acc += int'(mem[2 + r*SIZE + m]) * int'(mem[2 + NN + m*SIZE + c]);
        return 32'(acc);
    endfunction

    always_comb begin
        rdata = 32'hDEAD_BEEF;
        if (pv[RD_LAT-1]) rdata = mxu_read(pa[RD_LAT-1]);
    end

    int ma [NN];
    int mb [NN];

    task automatic outs_zero(input string tag);
        check_eq({tag, "_awaddr"}, awaddr, 0);
        check_eq({tag, "_wdata"}, wdata, 0);
        check_eq({tag, "_wready"}, wready, 0);
        check_eq({tag, "_araddr"}, araddr, 0);
        check_eq({tag, "_arready"}, arready, 0);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_res_idx"}, res_idx, 0);
        check_eq({tag, "_res_data"}, res_data, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    task automatic randomize_mats();
        for (int n = 0; n < NN; n++) begin
            ma[n] = int'($urandom_range(0, 255));
            mb[n] = int'($urandom_range(0, 255));
        end
    endtask

    // abuse: 0 none, 1 start pulse in WAIT, 2 reset during first R_WAIT
    task automatic run(input int cyc_val, input bit pmode, input int abuse, input bit chk96);
        int          expw_a [NWR];
        int          expw_d [NWR];
        longint      expr [NN];
        int          ar_cyc [NN];
        int          L, cyc, nw, nar, nres, last_w, last_res;
        bit          fin;
        L = cyc_val * WAIT_MUL + WAIT_ADD;
        for (int n = 0; n < NN; n++) begin
            expw_a[n]      = 2 + n;
            expw_d[n]      = ma[n];
            expw_a[NN + n] = 2 + NN + n;
            expw_d[NN + n] = mb[n];
        end
        expw_a[2*NN]     = 1;
        expw_d[2*NN]     = cyc_val;
        expw_a[2*NN + 1] = 0;
        expw_d[2*NN + 1] = 1;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                longint acc = 0;
                for (int m = 0; m < SIZE; m++)
                    acc += longint'(ma[r*SIZE + m]) * longint'(mb[m*SIZE + c]);
                expr[r*SIZE + c] = pmode ? acc : longint'(1001 + r*SIZE + c);
            end
        prod_mode = pmode;
        for (int n = 0; n < NN; n++) begin
            a_mat[n*8 +: 8] = 8'(ma[n]);
            b_mat[n*8 +: 8] = 8'(mb[n]);
        end
        cycles = 8'(cyc_val);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        a_mat  = {$urandom, $urandom, $urandom, $urandom};
        b_mat  = {$urandom, $urandom, $urandom, $urandom};
        cycles = 8'($urandom);
        check_eq("busy_after_start", busy, 1);
        cyc = 0; nw = 0; nar = 0; nres = 0; last_w = 0; last_res = 0; fin = 0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (wready) begin
                if (nw < NWR) begin
                    check_eq("w_addr", awaddr, expw_a[nw]);
                    check_eq("w_data", wdata, expw_d[nw]);
                end else begin
                    check_eq("extra_write", nw, NWR);
                end
                if (nw == 0) check_eq("first_w_latency", cyc, 1);
                else         check_eq("w_spacing", cyc - last_w, 3);
                last_w = cyc;
                nw++;
            end
            if (arready) begin
                if (nar == 0) begin
                    check_eq("writes_before_read", nw, NWR);
                    check_eq("wait_len", cyc - (last_w + 2), L);
                end
                if (nar < NN) begin
                    check_eq("r_addr", araddr, 1 + nar);
                    ar_cyc[nar] = cyc;
                end else begin
                    check_eq("extra_read", nar, NN);
                end
                nar++;
            end
            if (res_valid) begin
                if (nres < NN) begin
                    check_eq("res_idx", res_idx, nres);
                    check_eq("res_data", res_data, expr[nres]);
                    check_eq("res_timing", cyc - ar_cyc[nres], RD_LAT + 1);
                    if (chk96 && nres == 0) check_eq("k0_is_96", res_data, 96);
                end else begin
                    check_eq("extra_result", nres, NN);
                end
                last_res = cyc;
                nres++;
            end
            if (done) begin
                check_eq("done_after_all", nres, NN);
                check_eq("busy_low_on_done", busy, 0);
                check_eq("done_timing", cyc - last_res, 1);
                start = 1'b1;
                fin = 1;
            end
            if (abuse == 1 && nw == NWR && nar == 0 && cyc == last_w + 4) start = 1'b1;
            if (abuse == 2 && nar == 1 && cyc == ar_cyc[0] + 1) begin
                reset = 1'b0;
                fin = 1;
            end
        end
        if (!fin) check_eq("timeout", 0, 1);
        if (abuse == 2) begin
            @(negedge clk);
            reset = 1'b1;
            outs_zero("rst_in_rwait");
            repeat (20) begin
                @(negedge clk);
                check_eq("quiet_after_rst", {res_valid, done, busy, arready, wready}, 0);
            end
        end else begin
            @(negedge clk);
            start = 1'b0;
            check_eq("done_one_cycle", done, 0);
            check_eq("start_in_done_ignored", busy, 0);
        end
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b1;
        cycles = 8'd0;
        a_mat  = '0;
        b_mat  = '0;
        repeat (2) @(negedge clk);
        outs_zero("reset");
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_eq("start_with_reset_ignored", busy, 0);

        ma = '{5,2,6,1, 0,6,2,0, 3,8,1,4, 1,8,5,6};
        mb = '{7,5,8,0, 1,8,2,6, 9,4,3,8, 5,3,7,9};
        run(20, 1'b1, 0, 1'b1);

        randomize_mats();
        run(0, 1'b0, 1, 1'b0);

        randomize_mats();
        run(255, 1'b1, 0, 1'b0);

        randomize_mats();
        run(int'($urandom_range(1, 60)), 1'b1, 0, 1'b0);

        randomize_mats();
        run(int'($urandom_range(0, 30)), 1'b1, 2, 1'b0);

        randomize_mats();
        run(int'($urandom_range(0, 30)), 1'b1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
